// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_pkg
// Brief   : Shared constants, refill state encoding and line-base helper.
// Revision: 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int IDX_W          = $clog2(WORDS_PER_LINE);
    localparam int OFFSET_W       = IDX_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } refill_state_t;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_refill_unit.sv
`default_nettype none
// ============================================================================
// Module  : cache_refill_unit
// Brief   : Miss handler: optional victim write-back, then critical-word-first
//           line fetch streamed back to the cache controller.
// Revision: 1.0 - initial release
// ============================================================================
module cache_refill_unit
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic [IDX_W-1:0]  wb_rd_idx,
    input  logic [DATA_W-1:0] wb_rd_data,
    output logic              fill_valid,
    output logic [IDX_W-1:0]  fill_idx,
    output logic [DATA_W-1:0] fill_data,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    refill_state_t     r_state;
    refill_state_t     w_next;
    logic [ADDR_W-1:0] r_miss_base;
    logic [ADDR_W-1:0] r_victim_base;
    logic [IDX_W-1:0]  r_crit;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_fill_valid;
    logic [IDX_W-1:0]  r_fill_idx;
    logic [DATA_W-1:0] r_fill_data;

    logic [IDX_W-1:0]  w_fill_word;
    logic              w_last;

    // Power-of-two line size: the narrow add wraps the index for free.
    assign w_fill_word = r_crit + r_cnt;
    assign w_last      = (r_cnt == IDX_W'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wb_rd_idx = '0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = req_wb ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_victim_base + (ADDR_W'(r_cnt) << 2);
                wb_rd_idx = r_cnt;
                mem_wdata = wb_rd_data;
                if (mem_ack && w_last) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = r_miss_base + (ADDR_W'(w_fill_word) << 2);
                if (mem_ack && w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_miss_base   <= '0;
            r_victim_base <= '0;
            r_crit        <= '0;
            r_cnt         <= '0;
            r_fill_valid  <= 1'b0;
            r_fill_idx    <= '0;
            r_fill_data   <= '0;
        end else begin
            r_fill_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_miss_base   <= line_base(req_addr);
                        r_victim_base <= line_base(wb_addr);
                        r_crit        <= req_addr[OFFSET_W-1:2];
                        r_cnt         <= '0;
                    end
                end
                ST_WB: begin
                    if (mem_ack) begin
                        r_cnt <= w_last ? '0 : r_cnt + IDX_W'(1);
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        r_cnt        <= w_last ? '0 : r_cnt + IDX_W'(1);
                        r_fill_valid <= 1'b1;
                        r_fill_idx   <= w_fill_word;
                        r_fill_data  <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fill_valid = r_fill_valid;
    assign fill_idx   = r_fill_idx;
    assign fill_data  = r_fill_data;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_refill_unit
// Brief   : Scoreboard bench with latency-configurable memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_refill_unit;
    import cache_pkg::*;

    localparam int W = WORDS_PER_LINE;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_wb = 1'b0;
    logic [ADDR_W-1:0] wb_addr = '0;
    logic [IDX_W-1:0]  wb_rd_idx;
    logic [DATA_W-1:0] wb_rd_data;
    logic              fill_valid;
    logic [IDX_W-1:0]  fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic              done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    cache_refill_unit dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wb(req_wb), .wb_addr(wb_addr), .wb_rd_idx(wb_rd_idx),
        .wb_rd_data(wb_rd_data), .fill_valid(fill_valid), .fill_idx(fill_idx),
        .fill_data(fill_data), .done(done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_txn_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } fill_t;

    mem_txn_t    exp_mem[$];
    fill_t       exp_fill[$];
    int          exp_lat[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          accept_cycle = 0;
    int          lat = 1;
    logic [31:0] victim[W];
    logic        noise = 1'b0;
    int          wait_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    // Memory model: acks after lat cycles of request; random ack noise while idle.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b)                wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end
    always @(posedge clk) noise <= 1'($urandom_range(0, 1));
    always @(posedge clk) cycle <= cycle + 1;

    assign mem_ack    = mem_req ? (wait_cnt >= lat - 1) : noise;
    assign mem_rdata  = mem_req ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    assign wb_rd_data = victim[wb_rd_idx];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor / scoreboard
    logic        prev_pending = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;
    logic        ready_due = 1'b0;

    always @(negedge clk) begin
        if (!rst_b) begin
            prev_pending = 1'b0;
            ready_due    = 1'b0;
        end else begin
            if (prev_pending && mem_req) begin
                chk("stable_addr", 64'(mem_addr), 64'(prev_addr));
                chk("stable_we", 64'(mem_we), 64'(prev_we));
                chk("stable_wdata", 64'(mem_wdata), 64'(prev_wdata));
            end
            prev_pending = mem_req && !mem_ack;
            prev_we      = mem_we;
            prev_addr    = mem_addr;
            prev_wdata   = mem_wdata;
            if (mem_req && mem_ack) begin
                if (exp_mem.size() == 0) fail_now("unexpected_mem_txn");
                else begin
                    mem_txn_t t;
                    t = exp_mem.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(t.we));
                    chk("mem_addr", 64'(mem_addr), 64'(t.addr));
                    if (t.we) chk("mem_wdata", 64'(mem_wdata), 64'(t.data));
                end
            end
            if (fill_valid) begin
                if (exp_fill.size() == 0) fail_now("unexpected_fill");
                else begin
                    fill_t f;
                    f = exp_fill.pop_front();
                    chk("fill_idx", 64'(fill_idx), 64'(f.idx));
                    chk("fill_data", 64'(fill_data), 64'(f.data));
                end
            end
            if (ready_due) chk("req_ready_after_done", 64'(req_ready), 64'd1);
            ready_due = 1'b0;
            if (done) begin
                if (exp_lat.size() == 0) fail_now("unexpected_done");
                else chk("done_latency", 64'(cycle - accept_cycle), 64'(exp_lat.pop_front()));
                chk("fill_drained_at_done", 64'(exp_fill.size()), 64'd0);
                ready_due = 1'b1;
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail_now("timeout_req_ready");
    endtask

    // Reference model: pushes everything the request must produce, then drives it.
    task automatic issue(input logic [31:0] a, input logic wb, input logic [31:0] va,
                         input logic [31:0] vseed, input int l, input logic hold);
        logic [31:0] mbase, vbase, ad;
        int          crit, idx;
        mem_txn_t    t;
        fill_t       f;
        wait_ready();
        lat   = l;
        mbase = a - (a % (W * 4));
        vbase = va - (va % (W * 4));
        crit  = int'((a / 4) % W);
        for (int i = 0; i < W; i++) victim[i] = vseed + 32'(i) * 32'h0101_0101;
        if (wb) begin
            for (int i = 0; i < W; i++) begin
                t.we = 1'b1; t.addr = vbase + 32'(4 * i); t.data = victim[i];
                exp_mem.push_back(t);
            end
        end
        for (int i = 0; i < W; i++) begin
            idx  = (crit + i) % W;
            ad   = mbase + 32'(4 * idx);
            t.we = 1'b0; t.addr = ad; t.data = '0;
            exp_mem.push_back(t);
            f.idx = idx; f.data = mem_word(ad);
            exp_fill.push_back(f);
        end
        exp_lat.push_back(l * W * (wb ? 2 : 1));
        req_valid    = 1'b1;
        req_addr     = a;
        req_wb       = wb;
        wb_addr      = va;
        accept_cycle = cycle + 1;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_lat.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_lat.size() != 0) fail_now("timeout_idle");
    endtask

    initial begin
        int n;
        for (int i = 0; i < W; i++) victim[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_fill_valid", 64'(fill_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_fill_data", 64'(fill_data), 64'd0);
        chk("rst_fill_idx", 64'(fill_idx), 64'd0);
        chk("rst_wb_rd_idx", 64'(wb_rd_idx), 64'd0);
        rst_b = 1'b1;

        issue(32'h0000_0008, 1'b0, 32'h0, 32'h0, 1, 1'b0);
        wait_idle();
        issue(32'h0000_0010, 1'b1, 32'h1234_5670, 32'hCAFE_BABE, 1, 1'b0);
        wait_idle();
        issue(32'h0000_0040, 1'b0, 32'h0, 32'h0, 3, 1'b0);
        wait_idle();

        // req_valid stays high through the first request
        issue(32'h0000_0084, 1'b0, 32'h0, 32'h0, 2, 1'b1);
        repeat (2) @(negedge clk);
        chk("busy_req_ready", 64'(req_ready), 64'd0);
        issue(32'h0000_0F18, 1'b1, 32'h0000_2220, 32'h1357_9BDF, 1, 1'b0);
        wait_idle();

        // Reset during the second fill word
        issue(32'h0000_0100, 1'b0, 32'h0, 32'h0, 1, 1'b0);
        n = 0;
        @(negedge clk);
        while (!fill_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!fill_valid) fail_now("timeout_first_fill");
        #2 rst_b = 1'b0;
        #1;
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_done", 64'(done), 64'd0);
        exp_mem.delete();
        exp_fill.delete();
        exp_lat.delete();
        repeat (2) @(negedge clk);
        chk("midrst_done_hold", 64'(done), 64'd0);
        rst_b = 1'b1;
        issue(32'h0000_0204, 1'b1, 32'h0000_3330, 32'hA5A5_0000, 2, 1'b0);
        wait_idle();

        issue(32'h0000_000C, 1'b0, 32'h0, 32'h0, 1, 1'b0);
        wait_idle();

        for (int k = 0; k < 40; k++) begin
            issue($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
                  int'($urandom_range(1, 4)), 1'b0);
        end
        wait_idle();

        chk("end_mem_queue", 64'(exp_mem.size()), 64'd0);
        chk("end_fill_queue", 64'(exp_fill.size()), 64'd0);
        chk("end_req_ready", 64'(req_ready), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
